// File: rtl/router_input_vc_if.sv
// Link-receiver and switch-side signals of one router input port.
interface router_input_vc_if #(
   parameter int NUM_VC = 2,
   parameter int WIDTH  = 16
);
   localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

   logic              packet_valid;
   logic [VC_W-1:0]   vc_in;
   logic [WIDTH-1:0]  down;
   logic              is_reading;
   logic [NUM_VC-1:0] credit_out;
   logic              overflow_err;
   logic              valid_out;
   logic [VC_W-1:0]   vc_out;
   logic [0:4]        port_request;
   logic [WIDTH-1:0]  to_switch;
   logic              is_read;

   modport slave (
      input  packet_valid, vc_in, down, is_read,
      output is_reading, credit_out, overflow_err, valid_out, vc_out, port_request, to_switch
   );

   modport master (
      output packet_valid, vc_in, down, is_read,
      input  is_reading, credit_out, overflow_err, valid_out, vc_out, port_request, to_switch
   );
endinterface

// File: rtl/router_input_vc.sv
// Router input port: per-VC FWFT FIFOs, credit return, dimension-order routing
// and a round-robin head-flit selector that holds its choice until the switch reads it.
module router_input_vc #(
   parameter int unsigned X_COORD      = 0,
   parameter int unsigned Y_COORD      = 0,
   parameter int          NUM_VC       = 2,
   parameter int          COORD_LENGTH = 4,
   parameter int          WIDTH        = 16,
   parameter int          LOG2_DEPTH   = 2,
   parameter bit          ROUTE_YX     = 1'b0
) (
   input logic              clk,
   input logic              rst,
   router_input_vc_if.slave bus
);
   localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int SLOTS = 1 << VC_W;

   localparam logic [0:4] REQ_LOCAL = 5'b00001;
   localparam logic [0:4] REQ_EAST  = 5'b00010;
   localparam logic [0:4] REQ_NORTH = 5'b00100;
   localparam logic [0:4] REQ_WEST  = 5'b01000;
   localparam logic [0:4] REQ_SOUTH = 5'b10000;

   typedef enum logic {ARB, HOLD} sel_state_e;
   typedef logic [LOG2_DEPTH:0] ptr_t;

   logic [WIDTH-1:0]  mem [NUM_VC][DEPTH];
   ptr_t              wr_ptr [NUM_VC];
   ptr_t              rd_ptr [NUM_VC];
   logic [NUM_VC-1:0] full, empty, push, pop;
   logic [SLOTS-1:0]  full_slot;

   sel_state_e        state_q, state_d;
   logic [VC_W-1:0]   lock_vc_q, lock_vc_d;
   logic [VC_W-1:0]   rr_ptr_q, rr_sel, sel;
   logic              valid_any;
   logic [NUM_VC-1:0] credit_q;
   logic              overflow_q;

   logic [WIDTH-1:0]        head;
   logic [COORD_LENGTH-1:0] dest_x, dest_y;
   logic                    x_gt, x_lt, y_gt, y_lt;
   logic [0:4]              route;

   // Extra pointer bit tells full from empty when the index bits match.
   always_comb begin
      for (int v = 0; v < NUM_VC; v++) begin
         empty[v] = (wr_ptr[v] == rd_ptr[v]);
         full[v]  = (wr_ptr[v][LOG2_DEPTH-1:0] == rd_ptr[v][LOG2_DEPTH-1:0]) &&
                    (wr_ptr[v][LOG2_DEPTH] != rd_ptr[v][LOG2_DEPTH]);
      end
   end

   // Unused VC codes read as full so a write to them is dropped and flagged.
   always_comb begin
      full_slot              = '1;
      full_slot[NUM_VC-1:0]  = full;
   end

   assign bus.is_reading = bus.packet_valid && !full_slot[bus.vc_in];
   assign valid_any      = |(~empty);

   // Scanning twice around the ring downward leaves the first non-empty VC at or after rr_ptr.
   always_comb begin
      rr_sel = '0;
      for (int i = 2*NUM_VC-1; i >= 0; i--) begin
         if (i >= int'(rr_ptr_q) && !empty[i % NUM_VC]) rr_sel = VC_W'(i % NUM_VC);
      end
   end

   assign sel = (state_q == HOLD) ? lock_vc_q : rr_sel;

   always_comb begin
      head = '0;
      push = '0;
      pop  = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         if (sel == VC_W'(v)) head = mem[v][rd_ptr[v][LOG2_DEPTH-1:0]];
         push[v] = bus.is_reading && (bus.vc_in == VC_W'(v));
         pop[v]  = valid_any && bus.is_read && (sel == VC_W'(v));
      end
   end

   assign dest_x = head[WIDTH-2 -: COORD_LENGTH];
   assign dest_y = head[WIDTH-2-COORD_LENGTH -: COORD_LENGTH];
   assign x_gt   = 32'(dest_x) > X_COORD;
   assign x_lt   = 32'(dest_x) < X_COORD;
   assign y_gt   = 32'(dest_y) > Y_COORD;
   assign y_lt   = 32'(dest_y) < Y_COORD;

   // NOTE: every signal driven in a combinational block gets a default first, so no path leaves it holding a value (which would infer a latch).
   always_comb begin
      route = REQ_LOCAL;
      if (ROUTE_YX) begin
         if      (y_gt) route = REQ_NORTH;
         else if (y_lt) route = REQ_SOUTH;
         else if (x_gt) route = REQ_EAST;
         else if (x_lt) route = REQ_WEST;
      end else begin
         if      (x_gt) route = REQ_EAST;
         else if (x_lt) route = REQ_WEST;
         else if (y_gt) route = REQ_NORTH;
         else if (y_lt) route = REQ_SOUTH;
      end
   end

   assign bus.valid_out    = valid_any;
   assign bus.vc_out       = valid_any ? sel   : '0;
   assign bus.to_switch    = valid_any ? head  : '0;
   assign bus.port_request = valid_any ? route : '0;
   assign bus.credit_out   = credit_q;
   assign bus.overflow_err = overflow_q;

   // A presented but unread flit pins the selection so the switch sees a stable request.
   always_comb begin
      state_d   = state_q;
      lock_vc_d = lock_vc_q;
      if (valid_any) begin
         if (bus.is_read) begin
            state_d = ARB;
         end else begin
            state_d   = HOLD;
            lock_vc_d = sel;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB;
         lock_vc_q  <= '0;
         rr_ptr_q   <= '0;
         credit_q   <= '0;
         overflow_q <= 1'b0;
         for (int v = 0; v < NUM_VC; v++) begin
            wr_ptr[v] <= '0;
            rd_ptr[v] <= '0;
         end
      end else begin
         state_q   <= state_d;
         lock_vc_q <= lock_vc_d;
         credit_q  <= pop;
         if (bus.packet_valid && !bus.is_reading) overflow_q <= 1'b1;
         if (valid_any && bus.is_read)
            rr_ptr_q <= (int'(sel) == NUM_VC-1) ? '0 : sel + 1'b1;
         for (int v = 0; v < NUM_VC; v++) begin
            if (push[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
            if (pop[v])  rd_ptr[v] <= rd_ptr[v] + 1'b1;
         end
      end
   end

   // NOTE: the flit storage has no reset; the pointers alone define which entries are valid, so resetting the array would only add cost.
   always_ff @(posedge clk) begin
      for (int v = 0; v < NUM_VC; v++) begin
         if (push[v]) mem[v][wr_ptr[v][LOG2_DEPTH-1:0]] <= bus.down;
      end
   end
endmodule

// File: tb/tb_router_input_vc.sv
// Directed bench for router_input_vc: routing (XY/YX), overflow, lock/hold,
// round-robin credits, simultaneous push/pop and mid-stream reset.
module tb_router_input_vc;
   localparam int P_LOCAL = 1;
   localparam int P_EAST  = 2;
   localparam int P_NORTH = 4;
   localparam int P_WEST  = 8;
   localparam int P_SOUTH = 16;

   logic clk = 1'b0;
   logic rst_a, rst_b, rst_c;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   router_input_vc_if #(.NUM_VC(2), .WIDTH(16)) a_if ();
   router_input_vc_if #(.NUM_VC(1), .WIDTH(16)) b_if ();
   router_input_vc_if #(.NUM_VC(3), .WIDTH(16)) c_if ();

   router_input_vc #(.X_COORD(1), .Y_COORD(1), .NUM_VC(2), .COORD_LENGTH(4), .WIDTH(16),
                     .LOG2_DEPTH(2), .ROUTE_YX(1'b0))
      u_a (.clk(clk), .rst(rst_a), .bus(a_if));

   router_input_vc #(.X_COORD(1), .Y_COORD(1), .NUM_VC(1), .COORD_LENGTH(4), .WIDTH(16),
                     .LOG2_DEPTH(2), .ROUTE_YX(1'b1))
      u_b (.clk(clk), .rst(rst_b), .bus(b_if));

   router_input_vc #(.X_COORD(2), .Y_COORD(2), .NUM_VC(3), .COORD_LENGTH(4), .WIDTH(16),
                     .LOG2_DEPTH(2), .ROUTE_YX(1'b0))
      u_c (.clk(clk), .rst(rst_c), .bus(c_if));

   function automatic logic [15:0] mk(input logic [3:0] dx, input logic [3:0] dy, input logic [6:0] pl);
      return {1'b0, dx, dy, pl};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [1:0]  exp_vc   [6];
   logic [15:0] exp_flit [6];
   int          exp_port [6];

   initial begin
      exp_vc   = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
      exp_flit = '{mk(2,2,40), mk(0,5,42), mk(2,0,44), mk(2,2,41), mk(0,5,43), mk(2,0,45)};
      exp_port = '{P_LOCAL, P_WEST, P_SOUTH, P_LOCAL, P_WEST, P_SOUTH};

      a_if.packet_valid = 0; a_if.vc_in = '0; a_if.down = '0; a_if.is_read = 0;
      b_if.packet_valid = 0; b_if.vc_in = '0; b_if.down = '0; b_if.is_read = 0;
      c_if.packet_valid = 0; c_if.vc_in = '0; c_if.down = '0; c_if.is_read = 0;
      rst_a = 1; rst_b = 1; rst_c = 1;
      tick(); tick();
      rst_a = 0; rst_b = 0; rst_c = 0;
      #1;
      check("rst_valid",    32'(a_if.valid_out),    0);
      check("rst_port",     32'(a_if.port_request), 0);
      check("rst_to_sw",    32'(a_if.to_switch),    0);
      check("rst_vc_out",   32'(a_if.vc_out),       0);
      check("rst_overflow", 32'(a_if.overflow_err), 0);
      check("rst_credit",   32'(a_if.credit_out),   0);
      check("rst_b_valid",  32'(b_if.valid_out),    0);
      check("rst_c_valid",  32'(c_if.valid_out),    0);

      // XY routing at (1,1): EAST, then LOCAL, then WEST
      a_if.packet_valid = 1; a_if.vc_in = 1'b0; a_if.down = mk(3,0,1); #1;
      check("xy_accept",    32'(a_if.is_reading), 1);
      check("xy_no_bypass", 32'(a_if.valid_out),  0);
      tick(); a_if.packet_valid = 0; #1;
      check("xy_east_valid", 32'(a_if.valid_out),    1);
      check("xy_east_port",  32'(a_if.port_request), P_EAST);
      check("xy_east_flit",  32'(a_if.to_switch),    32'(mk(3,0,1)));
      check("xy_east_vc",    32'(a_if.vc_out),       0);
      a_if.is_read = 1;
      tick(); a_if.is_read = 0; #1;
      check("xy_credit_pulse", 32'(a_if.credit_out), 1);
      check("xy_empty",        32'(a_if.valid_out),  0);
      a_if.packet_valid = 1; a_if.vc_in = 1'b0; a_if.down = mk(1,1,2);
      tick(); a_if.packet_valid = 0; #1;
      check("xy_credit_one_cycle", 32'(a_if.credit_out),   0);
      check("xy_local_port",       32'(a_if.port_request), P_LOCAL);
      a_if.is_read = 1;
      tick(); a_if.is_read = 0;
      a_if.packet_valid = 1; a_if.vc_in = 1'b0; a_if.down = mk(0,1,3);
      tick(); a_if.packet_valid = 0; #1;
      check("xy_west_port", 32'(a_if.port_request), P_WEST);
      a_if.is_read = 1;
      tick();
      // is_read with nothing presented must not pop or credit
      tick(); a_if.is_read = 0; #1;
      check("idle_read_no_credit", 32'(a_if.credit_out), 0);

      // Fill VC0 (depth 4) unread; the presented head must stay put
      for (int k = 0; k < 4; k++) begin
         a_if.packet_valid = 1; a_if.vc_in = 1'b0; a_if.down = mk(2,1,7'(10+k)); #1;
         check("fill_accept", 32'(a_if.is_reading), 1);
         tick(); a_if.packet_valid = 0; #1;
         check("fill_hold_flit", 32'(a_if.to_switch),    32'(mk(2,1,10)));
         check("fill_hold_vc",   32'(a_if.vc_out),       0);
         check("fill_hold_port", 32'(a_if.port_request), P_EAST);
      end
      a_if.packet_valid = 1; a_if.vc_in = 1'b0; a_if.down = mk(2,1,14); #1;
      check("full_reject",       32'(a_if.is_reading),   0);
      check("ovf_before_edge",   32'(a_if.overflow_err), 0);
      tick(); a_if.packet_valid = 0; #1;
      check("ovf_set",           32'(a_if.overflow_err), 1);
      check("ovf_hold_flit",     32'(a_if.to_switch),    32'(mk(2,1,10)));

      // VC1 gets data while VC0 is locked (rr_ptr points at VC1)
      a_if.packet_valid = 1; a_if.vc_in = 1'b1; a_if.down = mk(0,1,20); #1;
      check("vc1_accept", 32'(a_if.is_reading), 1);
      tick(); a_if.packet_valid = 0; #1;
      check("lock_vc_out", 32'(a_if.vc_out),    0);
      check("lock_flit",   32'(a_if.to_switch), 32'(mk(2,1,10)));
      a_if.packet_valid = 1; a_if.vc_in = 1'b1; a_if.down = mk(1,3,21);
      tick(); a_if.packet_valid = 0;
      a_if.is_read = 1;
      tick(); a_if.is_read = 0; #1;
      check("rr_credit_vc0", 32'(a_if.credit_out),   1);
      check("rr_vc1_vc",     32'(a_if.vc_out),       1);
      check("rr_vc1_flit",   32'(a_if.to_switch),    32'(mk(0,1,20)));
      check("rr_vc1_port",   32'(a_if.port_request), P_WEST);

      // Simultaneous push and pop on VC1 at occupancy 2
      a_if.is_read = 1; a_if.packet_valid = 1; a_if.vc_in = 1'b1; a_if.down = mk(1,0,22); #1;
      check("pushpop_accept", 32'(a_if.is_reading), 1);
      tick(); a_if.packet_valid = 0; #1;
      check("pushpop_credit", 32'(a_if.credit_out), 2);
      check("pushpop_next",   32'(a_if.to_switch),  32'(mk(2,1,11)));
      tick();
      check("drain1_credit", 32'(a_if.credit_out),   1);
      check("drain1_flit",   32'(a_if.to_switch),    32'(mk(1,3,21)));
      check("drain1_port",   32'(a_if.port_request), P_NORTH);
      tick();
      check("drain2_credit", 32'(a_if.credit_out), 2);
      check("drain2_flit",   32'(a_if.to_switch),  32'(mk(2,1,12)));
      tick();
      check("drain3_credit", 32'(a_if.credit_out),   1);
      check("drain3_flit",   32'(a_if.to_switch),    32'(mk(1,0,22)));
      check("drain3_port",   32'(a_if.port_request), P_SOUTH);
      tick();
      check("drain4_credit", 32'(a_if.credit_out), 2);
      check("drain4_flit",   32'(a_if.to_switch),  32'(mk(2,1,13)));
      tick(); a_if.is_read = 0; #1;
      check("drain5_credit", 32'(a_if.credit_out), 1);
      check("drain5_empty",  32'(a_if.valid_out),  0);
      check("drain5_to_sw",  32'(a_if.to_switch),  0);
      tick();
      check("drain_credit_clear", 32'(a_if.credit_out),   0);
      check("ovf_sticky",         32'(a_if.overflow_err), 1);

      // Reset mid-stream wins over a same-cycle write and read
      a_if.packet_valid = 1; a_if.vc_in = 1'b0; a_if.down = mk(3,3,30);
      tick();
      a_if.vc_in = 1'b1; a_if.down = mk(3,3,31);
      tick();
      rst_a = 1; a_if.vc_in = 1'b0; a_if.down = mk(0,0,33); a_if.is_read = 1;
      tick(); rst_a = 0; a_if.packet_valid = 0; a_if.is_read = 0; #1;
      check("mid_rst_valid",  32'(a_if.valid_out),    0);
      check("mid_rst_port",   32'(a_if.port_request), 0);
      check("mid_rst_to_sw",  32'(a_if.to_switch),    0);
      check("mid_rst_vc",     32'(a_if.vc_out),       0);
      check("mid_rst_ovf",    32'(a_if.overflow_err), 0);
      check("mid_rst_credit", 32'(a_if.credit_out),   0);
      a_if.packet_valid = 1; a_if.vc_in = 1'b1; a_if.down = mk(2,2,32); #1;
      check("post_rst_accept", 32'(a_if.is_reading), 1);
      check("post_rst_nobyp",  32'(a_if.valid_out),  0);
      tick(); a_if.packet_valid = 0; #1;
      check("post_rst_valid", 32'(a_if.valid_out), 1);
      check("post_rst_vc",    32'(a_if.vc_out),    1);
      check("post_rst_flit",  32'(a_if.to_switch), 32'(mk(2,2,32)));

      // YX routing at (1,1), single VC
      b_if.packet_valid = 1; b_if.vc_in = 1'b0; b_if.down = mk(3,0,50);
      tick(); b_if.packet_valid = 0; #1;
      check("yx_south", 32'(b_if.port_request), P_SOUTH);
      b_if.is_read = 1;
      tick(); b_if.is_read = 0; #1;
      check("yx_credit", 32'(b_if.credit_out), 1);
      b_if.packet_valid = 1; b_if.vc_in = 1'b0; b_if.down = mk(1,2,51);
      tick(); b_if.packet_valid = 0; #1;
      check("yx_north", 32'(b_if.port_request), P_NORTH);
      b_if.packet_valid = 1; b_if.vc_in = 1'b1; b_if.down = mk(0,0,52); #1;
      check("bad_vc_reject", 32'(b_if.is_reading), 0);
      tick(); b_if.packet_valid = 0; #1;
      check("bad_vc_ovf",  32'(b_if.overflow_err), 1);
      check("bad_vc_flit", 32'(b_if.to_switch),    32'(mk(1,2,51)));

      // Three VCs loaded, is_read held: round-robin 0,1,2,0,1,2
      for (int k = 0; k < 6; k++) begin
         c_if.packet_valid = 1;
         c_if.vc_in = 2'(k / 2);
         c_if.down  = mk(k < 2 ? 4'd2 : (k < 4 ? 4'd0 : 4'd2),
                         k < 2 ? 4'd2 : (k < 4 ? 4'd5 : 4'd0), 7'(40 + k));
         tick();
      end
      c_if.packet_valid = 0;
      c_if.is_read = 1;
      for (int k = 0; k < 6; k++) begin
         #1;
         check("rr3_vc",   32'(c_if.vc_out),       32'(exp_vc[k]));
         check("rr3_flit", 32'(c_if.to_switch),    32'(exp_flit[k]));
         check("rr3_port", 32'(c_if.port_request), exp_port[k]);
         tick();
         check("rr3_credit", 32'(c_if.credit_out), 32'(3'b001 << exp_vc[k]));
      end
      c_if.is_read = 0; #1;
      check("rr3_empty", 32'(c_if.valid_out), 0);
      tick();
      check("rr3_credit_clear", 32'(c_if.credit_out), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/router_input_vc.md
# router_input_vc

Parametrised router input port with `NUM_VC` virtual channels, each backed by its own FIFO. The block returns per-VC credits upstream and routes each head flit by dimension order, selectable as XY or YX. A round-robin selector presents one VC's head flit at a time to the crossbar switch, together with a one-hot output-port request. It sits between a link receiver and the switch allocator in each mesh router tile.

## Interface
Parameters:
- `X_COORD`, 0, router x position (unsigned)
- `Y_COORD`, 0, router y position (unsigned)
- `NUM_VC`, 2, number of virtual channels (≥1); `VC_W` = max(1, $clog2(NUM_VC))
- `WIDTH`, `PACKET_LENGTH`, flit width; bit WIDTH-1 is the type bit, then dest_x (`COORD_LENGTH` bits), then dest_y (`COORD_LENGTH` bits) directly below
- `LOG2_DEPTH`, `LOG2_FIFO_DEPTH`, per-VC FIFO depth = 2**LOG2_DEPTH
- `ROUTE_YX`, 0, 0 = XY routing, 1 = YX routing

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `packet_valid`  in  1  upstream flit valid
- `vc_in`  in  VC_W  target VC of incoming flit
- `down`  in  WIDTH  incoming flit
- `is_reading`  out  1  flit accepted this cycle
- `credit_out`  out  NUM_VC  one-cycle credit pulse per popped flit
- `overflow_err`  out  1  sticky: write attempted to a full VC
- `valid_out`  out  1  a head flit is presented to the switch
- `vc_out`  out  VC_W  VC of presented flit
- `port_request`  out  [0:4]  one-hot request; 5'b00001 LOCAL, 5'b00010 EAST, 5'b00100 NORTH, 5'b01000 WEST, 5'b10000 SOUTH
- `to_switch`  out  WIDTH  presented flit
- `is_read`  in  1  switch consumes presented flit this cycle

## Operation
- Write: `is_reading` = `packet_valid` && !full[vc_in] (combinational). When high, `down` is pushed into FIFO[vc_in] at the edge.
- Dropped write: `packet_valid` with full[vc_in] drops the flit and sets `overflow_err` at the edge. Fullness is the pre-edge value, so a same-cycle pop of that VC does not rescue the write. `overflow_err` clears only on `rst`.
- `vc_in` ≥ NUM_VC counts as full: the flit is dropped and the error is set.
- Selection: `valid_out` = any VC non-empty.
  - If `locked` = 1, the selected VC is `lock_vc`.
  - Otherwise the selected VC is the first non-empty VC at or after `rr_ptr`, searching with wrap-around.
- Hold: at an edge with `valid_out` && !`is_read`, set `locked` = 1 and `lock_vc` = selected VC. The presented flit, `vc_out` and `port_request` must stay stable until read.
- Read: at an edge with `valid_out` && `is_read`:
  - pop the selected VC;
  - clear `locked`;
  - set `rr_ptr` = (selected + 1) mod NUM_VC;
  - set `credit_out[selected]` = 1 for the next cycle only.
  - `is_read` while `valid_out` = 0 is ignored.
- Routing: unsigned compare of the head's dest_x/dest_y against X_COORD/Y_COORD.
  - XY: dest_x > X → EAST; dest_x < X → WEST; otherwise dest_y > Y → NORTH, dest_y < Y → SOUTH, else LOCAL.
  - YX: the same rule with y resolved first.
- Outputs when `valid_out` = 0: `port_request` = 0, `to_switch` = 0, `vc_out` = 0.
- Each FIFO is first-word-fall-through. Simultaneous push and pop on one non-full VC keeps its occupancy unchanged.

## Timing
- Reset (`rst`=1 at an edge): all FIFOs empty, `rr_ptr` = 0, `locked` = 0, `credit_out` = 0, `overflow_err` = 0. Consequently `valid_out` = 0, `port_request` = 0, `to_switch` = 0, `vc_out` = 0. Reset wins over any same-cycle write or read; mid-packet contents are discarded.
- Latency: a flit written at edge N appears on `to_switch` in the cycle after edge N, provided its VC is selected. Zero-cycle bypass is not allowed.
- `credit_out[k]` is high for exactly the one cycle after each pop of VC k. Back-to-back pops give consecutive high cycles.
- `port_request`, `to_switch`, `vc_out` and `is_reading` are combinational from registered state and current inputs. No combinational path from `is_read` to any output.
- A VC sustains one flit per cycle. `credit_out` summed across VCs equals the number of accepted flits minus the current total occupancy.

## Test plan
- Single VC, XY, X=1,Y=1: write dest (3,0) → `valid_out` next cycle, `port_request`=5'b00010 (EAST). Write dest (1,1) → 5'b00001 (LOCAL).
- ROUTE_YX=1, X=1,Y=1, dest (3,0) → 5'b10000 (SOUTH); dest (1,2) → 5'b00100 (NORTH).
- NUM_VC=2, depth 4: fill VC0 with 4 flits, `is_read`=0 → 5th write gives `is_reading`=0 and `overflow_err`=1. `vc_out`, `to_switch` and `port_request` stay stable throughout.
- NUM_VC=3, all VCs loaded, `is_read` held 1 → `vc_out` sequence 0,1,2,0,… and `credit_out` pulses 001,010,100 one cycle after each pop.
- Simultaneous write to VC1 and pop of VC1 at occupancy 2 → occupancy stays 2, one credit pulse, FIFO order preserved.
- Assert `rst` mid-stream with flits queued → next cycle all outputs 0, `overflow_err`=0. A fresh write is presented one cycle after it is accepted.
